// File: rtl/uart_pkg.sv
// Shared definitions for the byte-serial UART transmitter.
// Holds the FSM state encoding, state width, data width and default bit period,
// plus the parity helper used when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int STATE_W          = 3;
  localparam int DATA_W           = 8;
  // 100 MHz core clock at 115200 baud
  localparam int CLKS_PER_BIT_DEF = 868;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the last count.
// Latency: tick_o is combinational from the registered count; one pulse per bit period.
// Backpressure: none; clr_i holds the count at zero (used while the FSM is idle/loading).
//
// Ports:
//   clk     system clock, rising edge
//   rstn    synchronous active-low reset
//   clr_i   synchronous clear; count forced to 0 and no tick while high
//   tick_o  high during the final cycle of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  output logic tick_o
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (at_max) begin
      // wrap at the bit boundary so the next bit starts counting from zero
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clr_i && at_max;

endmodule

// File: rtl/uart_tx_byte.sv
// UART transmitter: pulls one byte per frame from the burst FIFO and sends it 8N1 (8E1 with UART_PARITY_EN).
// Latency: handshake edge -> LOAD cycle -> start bit on the next edge; frame is 10 (11) bit periods.
// Backpressure: in_enable is high only in IDLE, so exactly one byte is requested per frame.
//
// Build option: define UART_PARITY_EN to insert an even-parity bit between the data and stop bits.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       synchronous active-low reset
//   in_valid   upstream byte available (FIFO output_valid)
//   in_enable  byte request to upstream (FIFO output_enable), registered
//   in_data    upstream byte, valid the cycle after a handshake edge (FIFO data_out)
//   tx         serial line, idle high, registered
//   busy       high from handshake until the end of the stop bit, registered
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_enable,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [2:0]        bit_idx_q;
  logic [2:0]        bit_idx_d;
  logic              tx_q;
  logic              tx_d;
  logic              in_enable_q;
  logic              in_enable_d;
  logic              busy_q;
  logic              busy_d;
`ifdef UART_PARITY_EN
  logic              parity_q;
  logic              parity_d;
`endif

  logic              baud_clr;
  logic              baud_tick;

  // The bit timer only runs while a bit is on the line; in IDLE and LOAD it is
  // held at zero so the start bit always gets a full period.
  assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (baud_clr),
    .tick_o (baud_tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    in_enable_d = in_enable_q;
    busy_d      = busy_q;
`ifdef UART_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (in_valid && in_enable_q) begin
          // FIFO presents the byte after this edge; capture it in LOAD
          state_d     = ST_LOAD;
          in_enable_d = 1'b0;
          busy_d      = 1'b1;
        end
      end

      ST_LOAD: begin
        shift_d   = in_data;
        bit_idx_d = '0;
        tx_d      = 1'b0;
        state_d   = ST_START;
`ifdef UART_PARITY_EN
        parity_d  = even_parity(in_data);
`endif
      end

      ST_START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            // shift the consumed bit out; the next bit is shift_q[1]
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (baud_tick) begin
          state_d     = ST_IDLE;
          in_enable_d = 1'b1;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        tx_d        = 1'b1;
        in_enable_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      in_enable_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      in_enable_q <= in_enable_d;
      busy_q      <= busy_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx        = tx_q;
  assign in_enable = in_enable_q;
  assign busy      = busy_q;

endmodule
